// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and defaults for the divided-clock ratio meter.
package clk_ratio_meter_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int CNT_W_DEF    = 16;
    localparam int AVG_LOG2_DEF = 2;
    localparam int TIMEOUT_DEF  = 1024;

    // Timeout counter width; covers the full 2..65535 timeout range.
    localparam int TMO_W = 16;

    // Number of sig_in periods in one averaging window.
    function automatic int period_target(input int avg_log2);
        return 1 << avg_log2;
    endfunction

    localparam int PER_TGT_DEF = period_target(AVG_LOG2_DEF);

endpackage

// File: rtl/clk_ratio_meter_if.sv
// Request/result bundle between a controller and the ratio meter.
interface clk_ratio_meter_if
    import clk_ratio_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ratio;
    logic [CNT_W-1:0] high_total;
    logic             timeout;
    logic             ovf;

    // Controller side: issues start, reads results.
    modport master (
        output start,
        input  busy, done, ratio, high_total, timeout, ovf
    );

    // Meter side: accepts start, produces results.
    modport slave (
        input  start,
        output busy, done, ratio, high_total, timeout, ovf
    );
endinterface

// File: rtl/clk_ratio_meter_sync_rise_det.sv
// Two-flop synchroniser plus history flop for an asynchronous level; flags
// the first synchronised cycle after a 0->1 transition.
module sync_rise_det (
    input  logic clkin,
    input  logic nrst,
    input  logic sig_in,
    output logic level,
    output logic rise
);
    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Shift the sampled level down the chain.
    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchroniser and history registers.
    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
endmodule

// File: rtl/clk_ratio_meter.sv
// Counts clkin cycles and sig_in high cycles across 2^AVG_LOG2 periods of
// the divided clock, giving a fixed-point divide ratio and the high time.
module clk_ratio_meter
    import clk_ratio_meter_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic clkin,
    input  logic nrst,
    input  logic sig_in,
    clk_ratio_meter_if.slave bus
);
    localparam int                PER_W    = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(period_target(AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic level, rise;

    sync_rise_det u_sync (
        .clkin  (clkin),
        .nrst   (nrst),
        .sig_in (sig_in),
        .level  (level),
        .rise   (rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tot_q, tot_d, hi_q, hi_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             sat_q, sat_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             timeout_q, timeout_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] ratio_q, ratio_d, high_q, high_d;

    // Next-state and counter update for the measurement sequencer.
    always_comb begin
        // NOTE: every variable is given a default first so no branch can infer a latch.
        state_d   = state_q;
        tot_d     = tot_q;
        hi_d      = hi_q;
        per_d     = per_q;
        tmo_d     = tmo_q;
        sat_d     = sat_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        ratio_d   = ratio_q;
        high_d    = high_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ARM;
                    busy_d  = 1'b1;
                    tot_d   = '0;
                    hi_d    = '0;
                    per_d   = '0;
                    tmo_d   = '0;
                    sat_d   = 1'b0;
                end
            end

            ST_ARM, ST_MEAS: begin
                busy_d = 1'b1;
                if (state_q == ST_MEAS) begin
                    // Accumulators stick at all-ones; the overflow is remembered.
                    if (tot_q != CNT_MAX) tot_d = tot_q + CNT_W'(1);
                    else                  sat_d = 1'b1;
                    if (level) begin
                        if (hi_q != CNT_MAX) hi_d = hi_q + CNT_W'(1);
                        else                 sat_d = 1'b1;
                    end
                end

                if (rise) begin
                    tmo_d = '0;
                    if (state_q == ST_ARM) begin
                        // The arming edge opens the window but is not counted.
                        state_d = ST_MEAS;
                        tot_d   = '0;
                        hi_d    = '0;
                        per_d   = '0;
                        sat_d   = 1'b0;
                    end else begin
                        per_d = per_q + PER_W'(1);
                        if (per_q == PER_LAST) begin
                            // The closing edge's cycle belongs to the window.
                            state_d   = ST_DONE;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            ratio_d   = tot_d;
                            high_d    = hi_d;
                            timeout_d = 1'b0;
                            ovf_d     = sat_d;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    ratio_d   = '0;
                    high_d    = '0;
                    timeout_d = 1'b1;
                    ovf_d     = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_DONE: begin
                // Result cycle; a start seen here is dropped.
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            tot_q     <= '0;
            hi_q      <= '0;
            per_q     <= '0;
            tmo_q     <= '0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ratio_q   <= '0;
            high_q    <= '0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q   <= state_d;
            tot_q     <= tot_d;
            hi_q      <= hi_d;
            per_q     <= per_d;
            tmo_q     <= tmo_d;
            sat_q     <= sat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ratio_q   <= ratio_d;
            high_q    <= high_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ratio      = ratio_q;
    assign bus.high_total = high_q;
    assign bus.timeout    = timeout_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: four builds share clkin/nrst/sig_in,
// each measured from a table of sig_in waveforms with hand-computed results.
module tb_clk_ratio_meter;

    localparam int START_AT = 2;

    logic clkin;
    logic nrst;
    logic sig_in;
    logic [3:0] start_vec;

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    clk_ratio_meter_if #(.CNT_W(16)) if0 ();
    clk_ratio_meter_if #(.CNT_W(16)) if1 ();
    clk_ratio_meter_if #(.CNT_W(16)) if2 ();
    clk_ratio_meter_if #(.CNT_W(8))  if3 ();

    assign if0.start = start_vec[0];
    assign if1.start = start_vec[1];
    assign if2.start = start_vec[2];
    assign if3.start = start_vec[3];

    clk_ratio_meter #(.CNT_W(16), .AVG_LOG2(2), .TIMEOUT(1024)) u_main (
        .clkin(clkin), .nrst(nrst), .sig_in(sig_in), .bus(if0));
    clk_ratio_meter #(.CNT_W(16), .AVG_LOG2(0), .TIMEOUT(1024)) u_avg0 (
        .clkin(clkin), .nrst(nrst), .sig_in(sig_in), .bus(if1));
    clk_ratio_meter #(.CNT_W(16), .AVG_LOG2(2), .TIMEOUT(100)) u_tmo (
        .clkin(clkin), .nrst(nrst), .sig_in(sig_in), .bus(if2));
    clk_ratio_meter #(.CNT_W(8), .AVG_LOG2(2), .TIMEOUT(1024)) u_c8 (
        .clkin(clkin), .nrst(nrst), .sig_in(sig_in), .bus(if3));

    logic [3:0]  done_w, busy_w, tmo_w, ovf_w;
    logic [15:0] ratio_w [4];
    logic [15:0] high_w  [4];

    assign done_w = {if3.done, if2.done, if1.done, if0.done};
    assign busy_w = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign tmo_w  = {if3.timeout, if2.timeout, if1.timeout, if0.timeout};
    assign ovf_w  = {if3.ovf, if2.ovf, if1.ovf, if0.ovf};
    assign ratio_w[0] = if0.ratio;
    assign ratio_w[1] = if1.ratio;
    assign ratio_w[2] = if2.ratio;
    assign ratio_w[3] = {8'h00, if3.ratio};
    assign high_w[0]  = if0.high_total;
    assign high_w[1]  = if1.high_total;
    assign high_w[2]  = if2.high_total;
    assign high_w[3]  = {8'h00, if3.high_total};

    typedef struct {
        string name;
        int    sel;
        int    n_per;
        int    per [4];
        int    hi  [4];
        int    exp_ratio;
        int    exp_high;
        int    exp_tmo;
        int    exp_ovf;
        int    exp_lat;
    } vec_t;

    vec_t vecs [7];
    bit   pat [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build_pat(input vec_t v);
        pat.delete();
        for (int k = 0; k < v.n_per; k++)
            for (int c = 0; c < v.per[k]; c++)
                pat.push_back(c < v.hi[k]);
    endtask

    // Plays pat on sig_in, pulses start at START_AT, and watches one DUT.
    task automatic run_meas(input int sel, input int again_at, input bit start_in_done,
                            input int rst_at, input int budget,
                            output int n_done, output int done_iter,
                            output logic busy_arm, output logic busy_after,
                            output logic [15:0] r, output logic [15:0] h,
                            output logic t, output logic o, output logic [15:0] rst_snap);
        n_done = 0; done_iter = -1; busy_arm = 1'b0; busy_after = 1'b0;
        r = '0; h = '0; t = 1'b0; o = 1'b0; rst_snap = '0;
        for (int i = 0; i < budget; i++) begin
            bit done_now;
            @(negedge clkin);
            done_now = done_w[sel];
            if (done_now) begin
                n_done++;
                if (done_iter < 0) begin
                    done_iter = i;
                    r = ratio_w[sel];
                    h = high_w[sel];
                    t = tmo_w[sel];
                    o = ovf_w[sel];
                end
            end
            if (i == START_AT + 1) busy_arm = busy_w[sel];
            if (done_iter >= 0) busy_after = busy_after | busy_w[sel];
            sig_in = (pat.size() == 0) ? 1'b0 : pat[i % pat.size()];
            start_vec = '0;
            if (i == START_AT || i == again_at || (start_in_done && done_now))
                start_vec[sel] = 1'b1;
            if (i == rst_at) begin
                nrst = 1'b0;
                #1;
                rst_snap = ratio_w[sel] | high_w[sel] |
                           {12'h000, busy_w[sel], done_w[sel], tmo_w[sel], ovf_w[sel]};
            end
            if (i == rst_at + 1) nrst = 1'b1;
            if (done_iter >= 0 && i >= done_iter + 4) break;
        end
        start_vec = '0;
    endtask

    int          nd, di;
    logic        b_arm, b_after, t_o, o_o;
    logic [15:0] r_o, h_o, snap;

    initial begin
        vecs[0] = '{"div6",      0, 1, '{6, 0, 0, 0},   '{3, 0, 0, 0},  'h18, 12,   0, 0, -1};
        vecs[1] = '{"div7",      0, 1, '{7, 0, 0, 0},   '{4, 0, 0, 0},  'h1C, 16,   0, 0, -1};
        vecs[2] = '{"div7_avg0", 1, 1, '{7, 0, 0, 0},   '{4, 0, 0, 0},  7,    4,    0, 0, -1};
        vecs[3] = '{"frac11_4",  0, 4, '{3, 3, 3, 2},   '{1, 1, 1, 1},  'h0B, 4,    0, 0, -1};
        vecs[4] = '{"sat_c8",    3, 1, '{100, 0, 0, 0}, '{50, 0, 0, 0}, 'hFF, 'hC8, 0, 1, -1};
        vecs[5] = '{"stuck0",    2, 0, '{0, 0, 0, 0},   '{0, 0, 0, 0},  0,    0,    1, 0, 100};
        vecs[6] = '{"div6_tmo",  2, 1, '{6, 0, 0, 0},   '{3, 0, 0, 0},  'h18, 12,   0, 0, -1};

        nrst = 1'b0;
        sig_in = 1'b0;
        start_vec = '0;
        repeat (3) @(negedge clkin);
        check("rst.busy",  busy_w[0],  1'b0);
        check("rst.done",  done_w[0],  1'b0);
        check("rst.ratio", ratio_w[0], 16'h0);
        check("rst.high",  high_w[0],  16'h0);
        check("rst.tmo",   tmo_w[0],   1'b0);
        check("rst.ovf",   ovf_w[0],   1'b0);
        nrst = 1'b1;
        repeat (2) @(negedge clkin);

        for (int k = 0; k < 7; k++) begin
            build_pat(vecs[k]);
            run_meas(vecs[k].sel, -1, (k == 0), -1, 1000,
                     nd, di, b_arm, b_after, r_o, h_o, t_o, o_o, snap);
            check($sformatf("%s.n_done", vecs[k].name), nd, 1);
            check($sformatf("%s.busy_arm", vecs[k].name), b_arm, 1'b1);
            check($sformatf("%s.busy_after", vecs[k].name), b_after, 1'b0);
            check($sformatf("%s.ratio", vecs[k].name), r_o, vecs[k].exp_ratio);
            check($sformatf("%s.high", vecs[k].name), h_o, vecs[k].exp_high);
            check($sformatf("%s.tmo", vecs[k].name), t_o, vecs[k].exp_tmo);
            check($sformatf("%s.ovf", vecs[k].name), o_o, vecs[k].exp_ovf);
            if (vecs[k].exp_lat >= 0)
                check($sformatf("%s.arm_to_done", vecs[k].name), di - (START_AT + 1), vecs[k].exp_lat);
        end

        // Second start in the middle of MEAS must be ignored.
        build_pat(vecs[0]);
        run_meas(0, 20, 1'b0, -1, 1000, nd, di, b_arm, b_after, r_o, h_o, t_o, o_o, snap);
        check("restart.n_done", nd, 1);
        check("restart.ratio", r_o, 16'h18);
        check("restart.high", h_o, 16'd12);
        check("restart.busy_after", b_after, 1'b0);

        // Reset mid-MEAS: outputs clear at once and no done follows.
        run_meas(0, -1, 1'b0, 20, 80, nd, di, b_arm, b_after, r_o, h_o, t_o, o_o, snap);
        check("midrst.outputs", snap, 16'h0);
        check("midrst.n_done", nd, 0);
        check("midrst.ratio_tmo_dut", ratio_w[2], 16'h0);

        // Next measurement after the reset is correct.
        run_meas(0, -1, 1'b0, -1, 1000, nd, di, b_arm, b_after, r_o, h_o, t_o, o_o, snap);
        check("postrst.n_done", nd, 1);
        check("postrst.ratio", r_o, 16'h18);
        check("postrst.high", h_o, 16'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
- Measures a divided clock against the reference clock `clkin` and reports the divide ratio and high time in `clkin` cycles.
- The ratio is averaged over 2^AVG_LOG2 periods, so it is fixed-point with AVG_LOG2 fraction bits. This resolves both integer and fractional (m/n) divide ratios.
- Used as the on-chip checker/readback for the divider outputs. `sig_in` is treated as asynchronous data, never as a clock.

Parameters:
- CNT_W, 16, width of the total and high accumulators and of the outputs.
- AVG_LOG2, 2, log2 of the number of periods averaged; also the number of fraction bits in `ratio`.
- TIMEOUT, 1024, number of `clkin` cycles without a rising edge before the measurement aborts (range 2..65535).

Ports:
- clkin  in  1  reference clock; all logic on posedge.
- nrst  in  1  asynchronous active-low reset.
- sig_in  in  1  divided clock under test, asynchronous.
- start  in  1  one-cycle request to begin a measurement.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse when a result (or a timeout) is valid.
- ratio  out  CNT_W  total `clkin` cycles across 2^AVG_LOG2 periods, i.e. the fixed-point divide ratio.
- high_total  out  CNT_W  `clkin` cycles with the synchronised `sig_in` high, within the same window.
- timeout  out  1  last measurement aborted on timeout.
- ovf  out  1  last measurement saturated an accumulator.

Behaviour:
- Reset (asynchronous, `nrst`=0): state IDLE; `busy`, `done`, `timeout`, `ovf` = 0; `ratio` and `high_total` = 0; sync chain and all counters = 0. Asserting reset mid-measurement aborts at once, with no done pulse.
- Input conditioning:
  - 2-flop synchroniser s1→s2, then history flop s3.
  - rise = s2 & ~s3.
  - Latency: a `sig_in` change sampled at edge k gives rise high during the cycle after edge k+1.
- IDLE: when `start`=1, go to ARM. Clear the accumulators, the period count, and the timeout counter.
- ARM: wait for rise.
  - On rise: go to MEAS with tot=0, hi=0, per=0.
  - The rising-edge cycle itself is not counted.
- MEAS, every cycle:
  - tot+=1 (saturating).
  - If s2=1, hi+=1 (saturating).
  - On rise, per+=1.
  - When a rise makes per == 2^AVG_LOG2, go to DONE. The tot/hi values for that cycle are included in the result.
- Window definition: the window starts at the cycle after the first rise and ends at the cycle of the 2^AVG_LOG2-th subsequent rise. So tot = the exact sum of the period lengths.
- DONE (one cycle):
  - done=1; latch ratio=tot and high_total=hi; timeout=0; ovf=saturation flag.
  - Then go to IDLE. `busy` drops in this same cycle.
- Timeout:
  - In ARM or MEAS, a counter increments each cycle and clears on rise.
  - When it reaches TIMEOUT with no rise, go to DONE with timeout=1, ratio=0, high_total=0, ovf=0.
- Saturation: the accumulators stick at all-ones and set a sticky ovf, which is reported at DONE.
- `start` while busy is ignored, including in the DONE cycle.
- Outputs hold their values until the next DONE.
- No combinational path from any input to any output.

Decomposition:
- Shared package:
  - State enum {IDLE, ARM, MEAS, DONE}, 2-bit encoding.
  - Default constants for CNT_W, AVG_LOG2, TIMEOUT.
  - A helper constant for the period target, 2^AVG_LOG2.
- One sub-module: sync_rise_det. It holds the 2-flop synchroniser, the history flop, and the rise output, and is reusable by other divider checkers.
- FSM, counters and output registers stay in clk_ratio_meter.

Test Plan:
- Divide-by-6 (`sig_in` high 3 / low 3, phase-locked to `clkin`), start → after 4 periods, done=1, ratio=0x0018 (6.00), high_total=12, timeout=0, ovf=0.
- Divide-by-7 (high 4 / low 3) → ratio=0x001C (7.00), high_total=16. Repeat with the AVG_LOG2=0 build → ratio=7, high_total=4.
- Fractional 11/4 (periods 3,3,3,2, each high 1 cycle) → ratio=0x000B (2.75), high_total=4.
- `sig_in` stuck 0, TIMEOUT=100 → done exactly 100 cycles after entering ARM, timeout=1, ratio=0, high_total=0. Then a valid divide-by-6 run clears timeout.
- CNT_W=8, period 100 (high 50 / low 50) → ratio=0xFF, high_total=0xC8, ovf=1.
- `start` pulsed again mid-MEAS → ignored, a single done pulse. Separately, `nrst` pulsed mid-MEAS → busy=0 and all outputs 0 immediately, no done pulse; the next start measures correctly.
